pc_fetch_unit: RTL

PC_FETCH_UNIT -- requirements
Module: pc_fetch_unit

---
 rtl/pc_pkg.sv | 22 ++
 rtl/pc_fetch_unit_if.sv | 26 ++
 rtl/pc_next_mux.sv | 33 +++
 rtl/pc_fetch_unit.sv | 137 +++++++++++++
 4 files changed

// File: rtl/pc_pkg.sv
// Shared types and encodings for the PC fetch unit: FSM states, next-PC
// select codes and a small decode helper.
package pc_pkg;

    // Fetch sequencer states.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_FETCH = 2'b01,
        ST_READY = 2'b10
    } state_t;

    // Next-PC select encodings; the fourth code (2'b11) behaves as sequential.
    localparam logic [1:0] SEL_SEQ = 2'b00;
    localparam logic [1:0] SEL_BR  = 2'b01;
    localparam logic [1:0] SEL_JMP = 2'b10;

    // True when the select code takes its next PC from the target input.
    function automatic logic is_redirect(input logic [1:0] sel);
        return (sel == SEL_BR) || (sel == SEL_JMP);
    endfunction

endpackage : pc_pkg

// File: rtl/pc_fetch_unit_if.sv
// Instruction-memory request/acknowledge bus between the fetch unit
// (master) and the instruction memory (slave).
interface pc_fetch_unit_if #(
    parameter int unsigned XLEN = 32
) ();

    logic            imem_req;
    logic [XLEN-1:0] imem_addr;
    logic            imem_ack;
    logic [XLEN-1:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ack,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ack,
        output imem_rdata
    );

endinterface : pc_fetch_unit_if

// File: rtl/pc_next_mux.sv
// Combinational next-PC selection: sequential increment (wrapping modulo
// 2^XLEN) or branch/jump target, plus the alignment check on redirects.
module pc_next_mux
    import pc_pkg::*;
#(
    parameter int unsigned XLEN = 32,
    parameter int unsigned INC  = 4
) (
    input  logic [XLEN-1:0] pc,
    input  logic [1:0]      sel,
    input  logic [XLEN-1:0] target,
    output logic [XLEN-1:0] next_pc,
    output logic            misaligned
);

    // INC is a power of two, so the low bits that must be zero on a redirect
    // are exactly INC-1.
    localparam logic [XLEN-1:0] ALIGN_MASK = XLEN'(INC - 1);
    localparam logic [XLEN-1:0] STEP       = XLEN'(INC);

    // Pick the next PC and flag a redirect whose target is not INC-aligned.
    always_comb begin
        // NOTE: every output gets a default before any branch so no path can
        // leave it unassigned and infer a latch.
        next_pc    = pc + STEP;
        misaligned = 1'b0;
        if (is_redirect(sel)) begin
            next_pc    = target;
            misaligned = |(target & ALIGN_MASK);
        end
    end

endmodule : pc_next_mux

// File: rtl/pc_fetch_unit.sv
// Program-counter fetch unit: IDLE -> FETCH -> READY sequencer that fetches
// the instruction at pc_out, latches it into ir, and on request advances
// sequentially, redirects, or traps to TRAP_VEC (saving the PC in epc).
module pc_fetch_unit
    import pc_pkg::*;
#(
    parameter int unsigned     XLEN      = 32,
    parameter logic [XLEN-1:0] RESET_VEC = 32'h0000_0000,
    parameter logic [XLEN-1:0] TRAP_VEC  = 32'h0000_0080,
    parameter int unsigned     INC       = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            enable,
    input  logic [1:0]      sel,
    input  logic [XLEN-1:0] target,
    input  logic            trap,
    pc_fetch_unit_if.master imem,
    output logic [XLEN-1:0] pc_out,
    output logic [XLEN-1:0] ir,
    output logic            ir_valid,
    output logic [XLEN-1:0] epc,
    output logic            misalign
);

    state_t          state;
    state_t          state_nxt;

    logic [XLEN-1:0] next_pc;
    logic            next_misaligned;

    logic            pc_load;
    logic [XLEN-1:0] pc_d;
    logic            epc_load;
    logic            ir_load;
    logic            misalign_nxt;

    pc_next_mux #(
        .XLEN (XLEN),
        .INC  (INC)
    ) u_next_mux (
        .pc         (pc_out),
        .sel        (sel),
        .target     (target),
        .next_pc    (next_pc),
        .misaligned (next_misaligned)
    );

    // State register; reset parks the sequencer in IDLE without waiting for clk.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of block ordering.
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode and register load controls.
    always_comb begin
        state_nxt    = state;
        pc_load      = 1'b0;
        pc_d         = pc_out;
        epc_load     = 1'b0;
        ir_load      = 1'b0;
        misalign_nxt = 1'b0;

        unique case (state)
            ST_IDLE: begin
                state_nxt = ST_FETCH;
            end

            ST_FETCH: begin
                // Request and address stay put until memory acknowledges.
                if (imem.imem_ack) begin
                    ir_load   = 1'b1;
                    state_nxt = ST_READY;
                end
            end

            ST_READY: begin
                if (trap) begin
                    // External trap wins over any pending advance.
                    epc_load  = 1'b1;
                    pc_load   = 1'b1;
                    pc_d      = TRAP_VEC;
                    state_nxt = ST_FETCH;
                end else if (enable) begin
                    pc_load   = 1'b1;
                    state_nxt = ST_FETCH;
                    if (next_misaligned) begin
                        // A misaligned redirect becomes a trap and raises
                        // the one-cycle misalign pulse.
                        epc_load     = 1'b1;
                        pc_d         = TRAP_VEC;
                        misalign_nxt = 1'b1;
                    end else begin
                        pc_d = next_pc;
                    end
                end
            end

            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // Architectural registers: PC, instruction, exception PC, misalign pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_out   <= RESET_VEC;
            ir       <= '0;
            epc      <= '0;
            misalign <= 1'b0;
        end else begin
            if (pc_load) begin
                pc_out <= pc_d;
            end
            if (ir_load) begin
                ir <= imem.imem_rdata;
            end
            if (epc_load) begin
                epc <= pc_out;
            end
            misalign <= misalign_nxt;
        end
    end

    // Bus and status outputs decoded directly from state, so reset clears
    // them immediately.
    assign imem.imem_req  = (state == ST_FETCH);
    assign imem.imem_addr = pc_out;
    assign ir_valid       = (state == ST_READY);

endmodule : pc_fetch_unit
